// File: rtl/pcie_dual_csr_arbiter.sv
// pcie_dual_csr_arbiter
// ---------------------
// Lets the BAR masters of two PCIe hard IPs (link 1 = m0, link 2 = m1) share a
// single Avalon-MM CSR/PIO slave on clk_100. Round-robin arbitration, one
// outstanding transaction at a time, and a watchdog that aborts any
// transaction stuck waiting for slave accept or read data.
//
// Handshake: a master request is mX_read | mX_write (write wins if both are
// set). The master holds its command stable while mX_waitrequest = 1. The
// arbiter samples requests only in IDLE and accepts the command by driving
// mX_waitrequest low for exactly one cycle. The slave accepts s_read/s_write
// in a cycle with s_waitrequest = 0. Read data returns on the one-cycle
// strobes s_readdatavalid (slave side) and mX_readdatavalid (master side).
//
// Ports:
//   clk_100, reset           clock, synchronous active-high reset
//   mX_*  (X = 0, 1)         Avalon-MM slave-side ports facing each PCIe BAR
//   s_*                      Avalon-MM master-side ports facing the CSR bank
//   grant                    master currently owning the slave
//   busy                     high whenever the FSM is outside IDLE
//   timeout_count            number of aborted transactions (saturating)
//   state_dbg                current FSM state encoding
//
// All outputs come straight from registers.

module pcie_dual_csr_arbiter #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk_100,
  input  logic                reset,
  // master 0
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  // slave
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  // status
  output logic                grant,
  output logic                busy,
  output logic [15:0]         timeout_count,
  output logic [2:0]          state_dbg
);

  localparam int BE_W = DATA_W / 8;
  // The watchdog expires in the TIMEOUT-th counted cycle (count starts at 0).
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_ACK     = 3'd2,
    S_WAIT_RD = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t state_q, state_n;

  // Internal state
  logic              last_served, last_served_n; // master served most recently
  logic              is_write, is_write_n;       // type of the current command
  logic [15:0]       wd_cnt, wd_cnt_n;           // watchdog cycle counter
  logic [DATA_W-1:0] rd_buf, rd_buf_n;           // read data caught during ACK
  logic              rd_cap, rd_cap_n;           // rd_buf holds valid data
  logic              aborted, aborted_n;         // watchdog fired in ISSUE

  // Next values of the registered outputs
  logic [ADDR_W-1:0] s_address_n;
  logic              s_read_n, s_write_n;
  logic [DATA_W-1:0] s_writedata_n;
  logic [BE_W-1:0]   s_byteenable_n;
  logic              m0_waitrequest_n, m1_waitrequest_n;
  logic              m0_readdatavalid_n, m1_readdatavalid_n;
  logic [DATA_W-1:0] m0_readdata_n, m1_readdata_n;
  logic              grant_n, busy_n;
  logic [15:0]       timeout_count_n;

  // Combinational helpers
  logic              req0, req1, sel;
  logic              resp_now;
  logic [DATA_W-1:0] resp_data;
  logic [15:0]       tc_inc;
  logic [15:0]       wd_inc;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign tc_inc = (timeout_count == 16'hFFFF) ? timeout_count : timeout_count + 16'd1;
  assign wd_inc = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;

  assign state_dbg = state_q;

  always_comb begin
    state_n            = state_q;
    last_served_n      = last_served;
    is_write_n         = is_write;
    wd_cnt_n           = wd_cnt;
    rd_buf_n           = rd_buf;
    rd_cap_n           = rd_cap;
    aborted_n          = aborted;
    s_address_n        = s_address;
    s_read_n           = s_read;
    s_write_n          = s_write;
    s_writedata_n      = s_writedata;
    s_byteenable_n     = s_byteenable;
    m0_waitrequest_n   = 1'b1;
    m1_waitrequest_n   = 1'b1;
    m0_readdatavalid_n = 1'b0;
    m1_readdatavalid_n = 1'b0;
    m0_readdata_n      = m0_readdata;
    m1_readdata_n      = m1_readdata;
    grant_n            = grant;
    timeout_count_n    = timeout_count;
    sel                = 1'b0;
    resp_now           = 1'b0;
    resp_data          = rd_buf;

    unique case (state_q)
      S_IDLE: begin
        // Stray s_readdatavalid is deliberately not looked at here.
        if (req0 | req1) begin
          // On a tie the master not served last wins.
          sel            = (req0 & req1) ? ~last_served : req1;
          is_write_n     = sel ? m1_write : m0_write;
          s_address_n    = sel ? m1_address : m0_address;
          s_writedata_n  = sel ? m1_writedata : m0_writedata;
          s_byteenable_n = sel ? m1_byteenable : m0_byteenable;
          s_write_n      = is_write_n;
          s_read_n       = ~is_write_n;
          grant_n        = sel;
          wd_cnt_n       = 16'd0;
          rd_cap_n       = 1'b0;
          aborted_n      = 1'b0;
          state_n        = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wd_cnt_n = wd_inc;
        // Slave accept takes priority over a watchdog expiring the same cycle.
        if (!s_waitrequest || (wd_cnt >= WD_LIMIT)) begin
          s_read_n      = 1'b0;
          s_write_n     = 1'b0;
          last_served_n = grant;
          state_n       = S_ACK;
          if (grant) m1_waitrequest_n = 1'b0;
          else       m0_waitrequest_n = 1'b0;
          if (s_waitrequest) begin
            aborted_n       = 1'b1;
            timeout_count_n = tc_inc;
          end
        end
      end

      S_ACK: begin
        wd_cnt_n = wd_inc;
        if (is_write) begin
          state_n = S_IDLE;
        end else if (aborted) begin
          // Command never reached the slave; answer the read with ERR_DATA.
          resp_now  = 1'b1;
          resp_data = ERR_DATA;
        end else begin
          state_n = S_WAIT_RD;
          // A latency-1 slave returns data while we are still acking.
          if (s_readdatavalid) begin
            rd_buf_n = s_readdata;
            rd_cap_n = 1'b1;
          end
        end
      end

      S_WAIT_RD: begin
        wd_cnt_n = wd_inc;
        if (rd_cap) begin
          resp_now  = 1'b1;
          resp_data = rd_buf;
        end else if (s_readdatavalid) begin
          resp_now  = 1'b1;
          resp_data = s_readdata;
        end else if (wd_cnt >= WD_LIMIT) begin
          resp_now        = 1'b1;
          resp_data       = ERR_DATA;
          timeout_count_n = tc_inc;
        end
      end

      S_RESP: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (resp_now) begin
      state_n = S_RESP;
      if (grant) begin
        m1_readdata_n      = resp_data;
        m1_readdatavalid_n = 1'b1;
      end else begin
        m0_readdata_n      = resp_data;
        m0_readdatavalid_n = 1'b1;
      end
    end

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q          <= S_IDLE;
      last_served      <= 1'b1;
      is_write         <= 1'b0;
      wd_cnt           <= 16'd0;
      rd_buf           <= '0;
      rd_cap           <= 1'b0;
      aborted          <= 1'b0;
      s_address        <= '0;
      s_read           <= 1'b0;
      s_write          <= 1'b0;
      s_writedata      <= '0;
      s_byteenable     <= '0;
      m0_waitrequest   <= 1'b1;
      m1_waitrequest   <= 1'b1;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      grant            <= 1'b0;
      busy             <= 1'b0;
      timeout_count    <= 16'd0;
    end else begin
      state_q          <= state_n;
      last_served      <= last_served_n;
      is_write         <= is_write_n;
      wd_cnt           <= wd_cnt_n;
      rd_buf           <= rd_buf_n;
      rd_cap           <= rd_cap_n;
      aborted          <= aborted_n;
      s_address        <= s_address_n;
      s_read           <= s_read_n;
      s_write          <= s_write_n;
      s_writedata      <= s_writedata_n;
      s_byteenable     <= s_byteenable_n;
      m0_waitrequest   <= m0_waitrequest_n;
      m1_waitrequest   <= m1_waitrequest_n;
      m0_readdatavalid <= m0_readdatavalid_n;
      m1_readdatavalid <= m1_readdatavalid_n;
      m0_readdata      <= m0_readdata_n;
      m1_readdata      <= m1_readdata_n;
      grant            <= grant_n;
      busy             <= busy_n;
      timeout_count    <= timeout_count_n;
    end
  end

endmodule

// File: tb/tb_pcie_dual_csr_arbiter.sv
// Bench for pcie_dual_csr_arbiter, built with TIMEOUT = 8.
// Transactions come from a table of records. Each record carries the
// stimulus plus the hand-derived expected ack cycle, done cycle (first IDLE
// cycle), read data and abort flag, all relative to the request cycle (rel 0).
// Read data is checked through an expected queue.

module tb_pcie_dual_csr_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TO     = 8;

  // ---------------- clock / reset ----------------
  logic clk_100 = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_100 = ~clk_100;

  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]        m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic              grant, busy;
  logic [15:0]       timeout_count;
  logic [2:0]        state_dbg;

  pcie_dual_csr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO),
                          .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_100(clk_100), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .grant(grant), .busy(busy), .timeout_count(timeout_count),
    .state_dbg(state_dbg)
  );

  // ---------------- records ----------------
  typedef struct {
    bit          mst;       // requesting master
    bit          wr;        // 1 = write
    int          w;         // s_waitrequest high for rel 1..w
    int          lat;       // read data at rel (ack-1)+lat; 0 = never
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] rdata;     // slave read data
    int          exp_ack;   // rel cycle of the one-cycle waitrequest low
    int          exp_done;  // rel cycle busy is back to 0
    logic [31:0] exp_rdata; // data expected at the master
    bit          exp_tmo;   // watchdog abort expected
  } txn_t;

  function automatic txn_t mk(bit mst, bit wr, int w, int lat, logic [15:0] addr,
                              logic [31:0] data, logic [3:0] be, logic [31:0] rdata,
                              int ack, int done, logic [31:0] erd, bit tmo);
    txn_t t;
    t.mst = mst; t.wr = wr; t.w = w; t.lat = lat; t.addr = addr; t.data = data;
    t.be = be; t.rdata = rdata; t.exp_ack = ack; t.exp_done = done;
    t.exp_rdata = erd; t.exp_tmo = tmo;
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int tc_exp   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic drive_master(input txn_t t);
    if (t.mst == 1'b0) begin
      m0_address = t.addr; m0_writedata = t.data; m0_byteenable = t.be;
      m0_write = t.wr; m0_read = !t.wr;
    end else begin
      m1_address = t.addr; m1_writedata = t.data; m1_byteenable = t.be;
      m1_write = t.wr; m1_read = !t.wr;
    end
  endtask

  task automatic release_master(input bit mst);
    if (mst == 1'b0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  // Called in an IDLE cycle; that cycle is rel 0. Returns in the done cycle.
  task automatic run_txn(input txn_t t, input string tag);
    logic [7:0]  exp_ctl;
    logic        rw;
    logic [31:0] got;
    drive_master(t);
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    if (!t.wr) exp_q.push_back(t.exp_rdata);
    for (int rel = 1; rel <= t.exp_done; rel++) begin
      tick();
      // slave and master stimulus for this cycle
      s_waitrequest   = (rel <= t.w);
      s_readdatavalid = 1'b0;
      s_readdata      = $urandom;
      if (!t.wr && t.lat > 0 && rel == t.exp_ack - 1 + t.lat) begin
        s_readdatavalid = 1'b1;
        s_readdata      = t.rdata;
      end
      if (!t.wr && t.lat == 0 && rel >= t.exp_done - 1) begin
        s_readdatavalid = 1'b1;       // late data after the abort
        s_readdata      = 32'h33;
      end
      if (rel > t.exp_ack) release_master(t.mst);
      // expected control vector
      rw = (rel < t.exp_ack);
      exp_ctl[7] = rw & !t.wr;                                   // s_read
      exp_ctl[6] = rw & t.wr;                                    // s_write
      exp_ctl[5] = !(t.mst == 1'b0 && rel == t.exp_ack);         // m0_waitrequest
      exp_ctl[4] = !(t.mst == 1'b1 && rel == t.exp_ack);         // m1_waitrequest
      exp_ctl[3] = (t.mst == 1'b0) && !t.wr && rel == t.exp_done - 1;
      exp_ctl[2] = (t.mst == 1'b1) && !t.wr && rel == t.exp_done - 1;
      exp_ctl[1] = (rel < t.exp_done);                           // busy
      exp_ctl[0] = t.mst;                                        // grant
      check($sformatf("%s rel%0d ctl{rd,wr,wr0,wr1,rdv0,rdv1,busy,gnt}", tag, rel),
            {56'd0, s_read, s_write, m0_waitrequest, m1_waitrequest,
             m0_readdatavalid, m1_readdatavalid, busy, grant}, {56'd0, exp_ctl});
      if (s_read || s_write)
        check($sformatf("%s rel%0d s_cmd", tag, rel),
              {12'd0, s_address, s_writedata, s_byteenable}, {12'd0, t.addr, t.data, t.be});
      if (m0_readdatavalid || m1_readdatavalid) begin
        got = m1_readdatavalid ? m1_readdata : m0_readdata;
        if (exp_q.size() == 0) check($sformatf("%s rel%0d unexpected_rdv", tag, rel), 1, 0);
        else check($sformatf("%s rel%0d readdata", tag, rel), got, exp_q.pop_front());
      end
    end
    if (exp_q.size() != 0) begin
      check($sformatf("%s missing_rdv", tag), exp_q.size(), 0);
      exp_q.delete();
    end
    if (t.exp_tmo) tc_exp++;
    check($sformatf("%s timeout_count", tag), timeout_count, tc_exp);
  endtask

  // The second master is already requesting while the first is served.
  task automatic run_pair(input txn_t a, input txn_t b, input string tag);
    drive_master(b);
    run_txn(a, {tag, "_a"});
    run_txn(b, {tag, "_b"});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " s_bus"}, {10'd0, s_read, s_write, s_address, s_writedata, s_byteenable}, 64'd0);
    check({tag, " m_ctl"}, {58'd0, m0_waitrequest, m1_waitrequest, m0_readdatavalid,
                            m1_readdatavalid, grant, busy}, {58'd0, 6'b110000});
    check({tag, " m0_readdata"}, m0_readdata, 0);
    check({tag, " m1_readdata"}, m1_readdata, 0);
    check({tag, " timeout_count"}, timeout_count, 0);
    check({tag, " state"}, state_dbg, 0);
  endtask

  // ---------------- test ----------------
  txn_t tbl[10];

  initial begin
    tbl[0] = mk(0, 1, 0,  1, 16'h0004, 32'h0000_00A5, 4'hF, 32'h0,         2,  3, 32'h0,         0);
    tbl[1] = mk(0, 0, 0,  1, 16'h0008, 32'h0,         4'hF, 32'h11,        2,  5, 32'h11,        0);
    tbl[2] = mk(1, 1, 3,  0, 16'h0010, 32'h1234_5678, 4'h3, 32'h0,         5,  6, 32'h0,         0);
    tbl[3] = mk(1, 0, 1,  3, 16'h0020, 32'h0,         4'hF, 32'hCAFE_0001, 3,  7, 32'hCAFE_0001, 0);
    tbl[4] = mk(0, 0, 2,  2, 16'h0024, 32'h0,         4'hF, 32'h0BAD_F00D, 4,  7, 32'h0BAD_F00D, 0);
    tbl[5] = mk(0, 0, 0,  0, 16'h0030, 32'h0,         4'hF, 32'h0,         2, 10, 32'hDEAD_BEEF, 1);
    tbl[6] = mk(1, 1, 10, 0, 16'h0034, 32'hAAAA_5555, 4'hC, 32'h0,         9, 10, 32'h0,         1);
    tbl[7] = mk(1, 0, 9,  0, 16'h0038, 32'h0,         4'hF, 32'h0,         9, 11, 32'hDEAD_BEEF, 1);
    tbl[8] = mk(0, 1, 1,  0, 16'hFFFF, 32'hFFFF_FFFF, 4'h5, 32'h0,         3,  4, 32'h0,         0);
    tbl[9] = mk(1, 0, 2,  1, 16'h0044, 32'h0,         4'hF, 32'h7777_0009, 4,  7, 32'h7777_0009, 0);

    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;

    reset = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // stray read data in IDLE is never forwarded
    for (int i = 0; i < 3; i++) begin
      s_readdatavalid = 1'b1;
      s_readdata      = $urandom_range(1, 32'hFFFF);
      tick();
      check($sformatf("stray_idle%0d ctl", i),
            {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid,
             m1_readdatavalid, busy}, 7'b0011000);
      check($sformatf("stray_idle%0d state", i), state_dbg, 0);
    end
    s_readdatavalid = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("t%0d", i));

    // reset while waiting for read data: abandon, no response to m0
    drive_master(mk(0, 0, 0, 0, 16'h0050, 32'h0, 4'hF, 32'h0, 0, 0, 32'h0, 0));
    s_waitrequest = 1'b0;
    repeat (3) tick();
    check("rst_mid state_wait_rd", state_dbg, 3);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_mid");
    tc_exp = 0;
    reset = 1'b0;
    release_master(0);
    s_readdatavalid = 1'b1;
    s_readdata      = 32'h5A5A_5A5A;
    tick();
    s_readdatavalid = 1'b0;
    check("rst_mid stray ctl", {m0_readdatavalid, m1_readdatavalid, busy}, 3'b000);
    run_txn(mk(1, 0, 0, 1, 16'h0060, 32'h0, 4'hF, 32'h0000_0042, 2, 5, 32'h0000_0042, 0), "post_rst");

    // simultaneous reads: alternation
    run_pair(mk(0, 0, 0, 1, 16'h0100, 32'h0, 4'hF, 32'h11, 2, 5, 32'h11, 0),
             mk(1, 0, 0, 1, 16'h0104, 32'h0, 4'hF, 32'h22, 2, 5, 32'h22, 0), "pair1");
    run_pair(mk(0, 0, 0, 1, 16'h0108, 32'h0, 4'hF, 32'h55, 2, 5, 32'h55, 0),
             mk(1, 0, 0, 2, 16'h010C, 32'h0, 4'hF, 32'h66, 2, 5, 32'h66, 0), "pair2");
    run_txn(mk(0, 1, 0, 0, 16'h0110, 32'h0102_0304, 4'hF, 32'h0, 2, 3, 32'h0, 0), "m0_solo");
    run_pair(mk(1, 0, 0, 1, 16'h0114, 32'h0, 4'hF, 32'h77, 2, 5, 32'h77, 0),
             mk(0, 0, 1, 1, 16'h0118, 32'h0, 4'hF, 32'h88, 3, 6, 32'h88, 0), "pair3");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
